// File: rtl/vend_dispense_scheduler_if.sv
// Handshake and status bundle between the two front-panel requesters and
// the dispense scheduler. The requester side drives the requests; the
// scheduler drives the grants, the motor, the coin hopper and the stock levels.
interface vend_dispense_scheduler_if;
    logic       req_a;
    logic [1:0] prod_a;
    logic [4:0] chg_a;
    logic       req_b;
    logic [1:0] prod_b;
    logic [4:0] chg_b;
    logic       refill;
    logic       gnt_a;
    logic       gnt_b;
    logic       rej_a;
    logic       rej_b;
    logic       done_a;
    logic       done_b;
    logic       motor_en;
    logic [1:0] motor_sel;
    logic       coin_pulse;
    logic       busy;
    logic [3:0] stock1;
    logic [3:0] stock2;

    modport master (
        output req_a, prod_a, chg_a, req_b, prod_b, chg_b, refill,
        input  gnt_a, gnt_b, rej_a, rej_b, done_a, done_b,
        input  motor_en, motor_sel, coin_pulse, busy, stock1, stock2
    );

    modport slave (
        input  req_a, prod_a, chg_a, req_b, prod_b, chg_b, refill,
        output gnt_a, gnt_b, rej_a, rej_b, done_a, done_b,
        output motor_en, motor_sel, coin_pulse, busy, stock1, stock2
    );
endinterface

// File: rtl/vend_dispense_scheduler.sv
// Round-robin scheduler sharing one dispenser motor and one 5 Rs coin hopper
// between two requesters. Each vend runs: motor pulse, coin-by-coin change,
// completion pulse. Per-product stock is tracked and reloaded on refill.
// Every output is a register loaded from the next-state decode so that the
// visible outputs line up with the state being entered.
module vend_dispense_scheduler #(
    parameter int DISP_CYCLES = 4,
    parameter int COIN_GAP    = 2,
    parameter int STOCK_INIT  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    vend_dispense_scheduler_if.slave bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REJECT   = 3'd1;
    localparam logic [2:0] S_DISPENSE = 3'd2;
    localparam logic [2:0] S_CHANGE   = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam int         CNT_W     = 8;
    localparam logic [3:0] STOCK_RST = 4'(STOCK_INIT);

    logic [2:0]       r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [2:0]       r_coins, w_coins_next;
    logic [1:0]       r_prod, w_prod_next;
    logic             r_owner_b, w_owner_b_next;
    logic             r_rr_b, w_rr_b_next;
    logic [3:0]       r_stock1, w_stock1_next;
    logic [3:0]       r_stock2, w_stock2_next;

    logic             r_gnt_a, r_gnt_b, r_rej_a, r_rej_b, r_done_a, r_done_b;
    logic             r_motor_en, r_coin_pulse, r_busy;
    logic [1:0]       r_motor_sel;

    logic             w_any_req;
    logic             w_sel_b;
    logic [1:0]       w_sel_prod;
    logic [4:0]       w_sel_chg;
    logic [2:0]       w_sel_coins;
    logic             w_prod_ok;
    logic             w_arb;
    logic             w_accept;
    logic             w_reject;

    // Arbitration: a lone request wins; on a tie the requester not served last wins.
    always_comb begin
        w_any_req   = bus.req_a | bus.req_b;
        w_sel_b     = (bus.req_a & bus.req_b) ? r_rr_b : bus.req_b;
        w_sel_prod  = w_sel_b ? bus.prod_b : bus.prod_a;
        w_sel_chg   = w_sel_b ? bus.chg_b : bus.chg_a;
        w_sel_coins = 3'(w_sel_chg / 5'd5);
        w_prod_ok   = ((w_sel_prod == 2'b01) && (r_stock1 != 4'd0)) ||
                      ((w_sel_prod == 2'b10) && (r_stock2 != 4'd0));
        w_arb       = (r_state == S_IDLE) && !bus.refill && w_any_req;
        w_accept    = w_arb && w_prod_ok;
        w_reject    = w_arb && !w_prod_ok;
    end

    // Next-state, counters, latched vend parameters and stock bookkeeping.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_coins_next   = r_coins;
        w_prod_next    = r_prod;
        w_owner_b_next = r_owner_b;
        w_rr_b_next    = r_rr_b;
        w_stock1_next  = r_stock1;
        w_stock2_next  = r_stock2;
        case (r_state)
            S_IDLE: begin
                if (bus.refill) begin
                    w_stock1_next = STOCK_RST;
                    w_stock2_next = STOCK_RST;
                end else if (w_any_req) begin
                    w_rr_b_next    = ~w_sel_b;
                    w_owner_b_next = w_sel_b;
                    if (w_prod_ok) begin
                        w_state_next = S_DISPENSE;
                        w_cnt_next   = CNT_W'(DISP_CYCLES - 1);
                        w_coins_next = w_sel_coins;
                        w_prod_next  = w_sel_prod;
                        if (w_sel_prod == 2'b01) begin
                            w_stock1_next = r_stock1 - 4'd1;
                        end else begin
                            w_stock2_next = r_stock2 - 4'd1;
                        end
                    end else begin
                        w_state_next = S_REJECT;
                    end
                end
            end
            S_REJECT: begin
                w_state_next = S_IDLE;
            end
            S_DISPENSE: begin
                if (r_cnt == '0) begin
                    w_state_next = (r_coins != 3'd0) ? S_CHANGE : S_DONE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_CHANGE: begin
                w_coins_next = r_coins - 3'd1;
                if (r_coins > 3'd1) begin
                    w_state_next = S_GAP;
                    w_cnt_next   = CNT_W'(COIN_GAP - 1);
                end else begin
                    w_state_next = S_DONE;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_next = S_CHANGE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers; reset abandons any vend in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_coins   <= 3'd0;
            r_prod    <= 2'b00;
            r_owner_b <= 1'b0;
            r_rr_b    <= 1'b0;
            r_stock1  <= STOCK_RST;
            r_stock2  <= STOCK_RST;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_coins   <= w_coins_next;
            r_prod    <= w_prod_next;
            r_owner_b <= w_owner_b_next;
            r_rr_b    <= w_rr_b_next;
            r_stock1  <= w_stock1_next;
            r_stock2  <= w_stock2_next;
        end
    end

    // Registered outputs decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_gnt_a      <= 1'b0;
            r_gnt_b      <= 1'b0;
            r_rej_a      <= 1'b0;
            r_rej_b      <= 1'b0;
            r_done_a     <= 1'b0;
            r_done_b     <= 1'b0;
            r_motor_en   <= 1'b0;
            r_motor_sel  <= 2'b00;
            r_coin_pulse <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_gnt_a      <= w_accept & ~w_sel_b;
            r_gnt_b      <= w_accept & w_sel_b;
            r_rej_a      <= w_reject & ~w_sel_b;
            r_rej_b      <= w_reject & w_sel_b;
            r_done_a     <= (w_state_next == S_DONE) & ~w_owner_b_next;
            r_done_b     <= (w_state_next == S_DONE) & w_owner_b_next;
            r_motor_en   <= (w_state_next == S_DISPENSE);
            r_motor_sel  <= (w_state_next == S_DISPENSE) ? w_prod_next : 2'b00;
            r_coin_pulse <= (w_state_next == S_CHANGE);
            r_busy       <= (w_state_next != S_IDLE);
        end
    end

    assign bus.gnt_a      = r_gnt_a;
    assign bus.gnt_b      = r_gnt_b;
    assign bus.rej_a      = r_rej_a;
    assign bus.rej_b      = r_rej_b;
    assign bus.done_a     = r_done_a;
    assign bus.done_b     = r_done_b;
    assign bus.motor_en   = r_motor_en;
    assign bus.motor_sel  = r_motor_sel;
    assign bus.coin_pulse = r_coin_pulse;
    assign bus.busy       = r_busy;
    assign bus.stock1     = r_stock1;
    assign bus.stock2     = r_stock2;

endmodule

// File: tb/tb_vend_dispense_scheduler.sv
// Bench for vend_dispense_scheduler: directed scenarios followed by random
// requester traffic. A transaction-level model turns every accepted or
// rejected request into a per-cycle schedule of expected outputs.
module tb_vend_dispense_scheduler;

    localparam int D    = 4;
    localparam int G    = 2;
    localparam int SI   = 2;
    localparam int NCYC = 4096;

    logic clk = 1'b0;
    logic rst;

    vend_dispense_scheduler_if bus ();

    vend_dispense_scheduler #(
        .DISP_CYCLES(D),
        .COIN_GAP   (G),
        .STOCK_INIT (SI)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // stimulus values applied at the start of the next cycle
    logic       rst_v = 1'b0;
    logic       req_a_v = 1'b0, req_b_v = 1'b0, refill_v = 1'b0;
    logic [1:0] prod_a_v = 2'b00, prod_b_v = 2'b00;
    logic [4:0] chg_a_v = 5'd0, chg_b_v = 5'd0;
    bit         rand_mode = 1'b0;
    bit         chk_en = 1'b0;
    int         cyc = 0;

    // expected outputs, indexed by cycle
    bit         e_gnt_a[NCYC], e_gnt_b[NCYC], e_rej_a[NCYC], e_rej_b[NCYC];
    bit         e_done_a[NCYC], e_done_b[NCYC], e_motor[NCYC], e_coin[NCYC], e_busy[NCYC];
    logic [1:0] e_sel[NCYC];
    logic [3:0] e_s1[NCYC], e_s2[NCYC];

    // model state
    int m_s1 = SI, m_s2 = SI;
    bit m_rr_b = 1'b0;
    int m_free = 0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        check_val("gnt_a", 32'(bus.gnt_a), 32'(e_gnt_a[cyc]));
        check_val("gnt_b", 32'(bus.gnt_b), 32'(e_gnt_b[cyc]));
        check_val("rej_a", 32'(bus.rej_a), 32'(e_rej_a[cyc]));
        check_val("rej_b", 32'(bus.rej_b), 32'(e_rej_b[cyc]));
        check_val("done_a", 32'(bus.done_a), 32'(e_done_a[cyc]));
        check_val("done_b", 32'(bus.done_b), 32'(e_done_b[cyc]));
        check_val("motor_en", 32'(bus.motor_en), 32'(e_motor[cyc]));
        check_val("motor_sel", 32'(bus.motor_sel), 32'(e_sel[cyc]));
        check_val("coin_pulse", 32'(bus.coin_pulse), 32'(e_coin[cyc]));
        check_val("busy", 32'(bus.busy), 32'(e_busy[cyc]));
        check_val("stock1", 32'(bus.stock1), 32'(e_s1[cyc]));
        check_val("stock2", 32'(bus.stock2), 32'(e_s2[cyc]));
    endtask

    // Evaluate what the edge at the end of the current cycle does.
    task automatic model_edge();
        bit         sel_b, ok;
        logic [1:0] prod;
        int         chg, c, td, k;
        if (!rst_v) begin
            for (k = cyc + 1; k < cyc + 64 && k < NCYC; k++) begin
                e_gnt_a[k] = 0; e_gnt_b[k] = 0; e_rej_a[k] = 0; e_rej_b[k] = 0;
                e_done_a[k] = 0; e_done_b[k] = 0; e_motor[k] = 0; e_coin[k] = 0;
                e_busy[k] = 0; e_sel[k] = 2'b00;
            end
            m_s1 = SI; m_s2 = SI; m_rr_b = 1'b0; m_free = cyc + 1;
            chk_en = 1'b1;
        end else if (cyc >= m_free) begin
            if (refill_v) begin
                m_s1 = SI; m_s2 = SI;
            end else if (req_a_v || req_b_v) begin
                sel_b  = (req_a_v && req_b_v) ? m_rr_b : req_b_v;
                m_rr_b = !sel_b;
                prod   = sel_b ? prod_b_v : prod_a_v;
                chg    = int'(sel_b ? chg_b_v : chg_a_v);
                ok     = (prod == 2'b01 && m_s1 > 0) || (prod == 2'b10 && m_s2 > 0);
                if (ok) begin
                    if (prod == 2'b01) m_s1--; else m_s2--;
                    c  = chg / 5;
                    td = (c == 0) ? cyc + D + 1 : cyc + D + 1 + c + (c - 1) * G;
                    if (sel_b) e_gnt_b[cyc + 1] = 1; else e_gnt_a[cyc + 1] = 1;
                    for (k = 1; k <= D; k++) begin
                        e_motor[cyc + k] = 1;
                        e_sel[cyc + k]   = prod;
                    end
                    for (k = 0; k < c; k++) e_coin[cyc + D + 1 + k * (G + 1)] = 1;
                    if (sel_b) e_done_b[td] = 1; else e_done_a[td] = 1;
                    for (k = cyc + 1; k <= td; k++) e_busy[k] = 1;
                    m_free = td + 1;
                end else begin
                    if (sel_b) e_rej_b[cyc + 1] = 1; else e_rej_a[cyc + 1] = 1;
                    e_busy[cyc + 1] = 1;
                    m_free = cyc + 2;
                end
            end
        end
        e_s1[cyc + 1] = 4'(m_s1);
        e_s2[cyc + 1] = 4'(m_s2);
    endtask

    function automatic logic [1:0] rnd_prod();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 2'b00;
        if (r == 1) return 2'b11;
        if (r < 5)  return 2'b01;
        return 2'b10;
    endfunction

    // Requesters drop req the cycle after their gnt/rej; random traffic when enabled.
    task automatic agents();
        if (e_gnt_a[cyc] || e_rej_a[cyc]) begin
            req_a_v = 1'b0;
        end else if (rand_mode && !req_a_v && $urandom_range(0, 3) == 0) begin
            req_a_v = 1'b1; prod_a_v = rnd_prod(); chg_a_v = 5'($urandom_range(0, 31));
        end
        if (e_gnt_b[cyc] || e_rej_b[cyc]) begin
            req_b_v = 1'b0;
        end else if (rand_mode && !req_b_v && $urandom_range(0, 3) == 0) begin
            req_b_v = 1'b1; prod_b_v = rnd_prod(); chg_b_v = 5'($urandom_range(0, 31));
        end
        if (rand_mode) begin
            refill_v = ($urandom_range(0, 24) == 0);
            rst_v    = ($urandom_range(0, 299) != 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rst        = rst_v;
        bus.req_a  = req_a_v;  bus.prod_a = prod_a_v; bus.chg_a = chg_a_v;
        bus.req_b  = req_b_v;  bus.prod_b = prod_b_v; bus.chg_b = chg_b_v;
        bus.refill = refill_v;
        @(negedge clk);
        if (chk_en) compare_all();
        model_edge();
        agents();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_refill();
        refill_v = 1'b1; step(); refill_v = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.req_a = 0; bus.prod_a = 0; bus.chg_a = 0;
        bus.req_b = 0; bus.prod_b = 0; bus.chg_b = 0;
        bus.refill = 0;

        rst_v = 1'b0; run(2); rst_v = 1'b1; run(2);
        check_val("reset_stock1", 32'(bus.stock1), SI);

        // single A vend, no change
        req_a_v = 1; prod_a_v = 2'b01; chg_a_v = 5'd0; run(8);
        check_val("a_vend_stock1", 32'(bus.stock1), 1);
        $display("vend A prod1 chg0 cycle %0d", cyc);

        // single B vend, two coins
        req_b_v = 1; prod_b_v = 2'b10; chg_b_v = 5'd10; run(12);
        check_val("b_vend_stock2", 32'(bus.stock2), 1);
        $display("vend B prod2 chg10 cycle %0d", cyc);

        // refill in IDLE
        pulse_refill(); run(1);
        check_val("refill_stock1", 32'(bus.stock1), SI);
        check_val("refill_stock2", 32'(bus.stock2), SI);
        $display("refill idle cycle %0d", cyc);

        // contention twice
        req_a_v = 1; prod_a_v = 2'b01; chg_a_v = 5'd5;
        req_b_v = 1; prod_b_v = 2'b10; chg_b_v = 5'd0; run(25);
        $display("contention 1 cycle %0d", cyc);
        req_a_v = 1; req_b_v = 1; run(25);
        $display("contention 2 cycle %0d", cyc);

        // sold out and invalid code
        pulse_refill();
        req_a_v = 1; prod_a_v = 2'b01; chg_a_v = 5'd0; run(8);
        req_a_v = 1; run(8);
        req_a_v = 1; run(4);
        check_val("soldout_stock1", 32'(bus.stock1), 0);
        check_val("soldout_motor", 32'(bus.motor_en), 0);
        req_a_v = 1; prod_a_v = 2'b11; run(4);
        $display("sold out / invalid cycle %0d", cyc);

        // refill ignored during DISPENSE
        req_b_v = 1; prod_b_v = 2'b10; chg_b_v = 5'd0; run(3);
        pulse_refill(); run(6);
        $display("refill during dispense cycle %0d stock2 %0d", cyc, bus.stock2);

        // reset during CHANGE after two coins
        pulse_refill(); run(1);
        req_b_v = 1; prod_b_v = 2'b10; chg_b_v = 5'd30; run(10);
        rst_v = 1'b0; run(1); rst_v = 1'b1; run(1);
        check_val("rst_busy", 32'(bus.busy), 0);
        check_val("rst_coin", 32'(bus.coin_pulse), 0);
        check_val("rst_stock2", 32'(bus.stock2), SI);
        run(3);
        $display("reset mid-change cycle %0d", cyc);

        // random traffic
        rand_mode = 1'b1;
        run(2000);
        rand_mode = 1'b0; rst_v = 1'b1; refill_v = 1'b0;
        run(40);
        $display("random phase end cycle %0d", cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
